// File: rtl/ita_gelu_ctrl.sv
// ita_gelu_ctrl: frame sequencer for the two-stage ITAGelu datapath.
// Issues activations into the free-running datapath under a credit rule.
// Tracks the two pipeline stages with valid/last tags.
// Captures results into a small output FIFO, so downstream stalls never
// stall the datapath.
module ita_gelu_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned LEN_W      = 16
) (
   input  logic             io_clk,
   input  logic             io_rst,
   input  logic             io_start_i,
   input  logic [LEN_W-1:0] io_len_i,
   output logic             io_busy_o,
   output logic             io_done_o,
   input  logic             io_cfg_we_i,
   input  logic [15:0]      io_cfg_b_i,
   input  logic [15:0]      io_cfg_c_i,
   output logic             io_cfg_err_o,
   input  logic             io_in_valid_i,
   output logic             io_in_ready_o,
   input  logic [7:0]       io_in_data_i,
   output logic             io_out_valid_o,
   input  logic             io_out_ready_i,
   output logic [25:0]      io_out_data_o,
   output logic             io_out_last_o,
   output logic [7:0]       io_gelu_data_o,
   output logic [15:0]      io_gelu_b_o,
   output logic [15:0]      io_gelu_c_o,
   output logic             io_gelu_calc_en_o,
   output logic             io_gelu_calc_en_q_o,
   input  logic [25:0]      io_gelu_data_i
);

   localparam int unsigned     CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned     PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W:0]  OCC_MAX  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic             l1_q, l1_d, l2_q, l2_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [15:0]      b_q, b_d, c_q, c_d;
   logic             cfg_err_q, cfg_err_d;
   logic [26:0]      mem_q [FIFO_DEPTH];

   logic [CNT_W:0]   occ;
   logic             credit, issue, rem_is_one, fifo_empty, drain_done;
   logic             push, pop;

   // Occupancy counts stored plus in-flight results; a same-cycle pop is not credited.
   assign occ        = (CNT_W + 1)'(fifo_cnt_q) + (CNT_W + 1)'(s1_v_q) + (CNT_W + 1)'(s2_v_q);
   assign credit     = occ < OCC_MAX;
   assign issue      = (state_q == ST_RUN) && io_in_valid_i && credit;
   assign rem_is_one = rem_q == LEN_W'(1);
   assign fifo_empty = fifo_cnt_q == '0;
   assign drain_done = (state_q == ST_DRAIN) && !s1_v_q && !s2_v_q && fifo_empty;
   assign push       = s2_v_q;
   assign pop        = !fifo_empty && io_out_ready_i;

   // Frame FSM, remaining-element counter and pipeline tag next state
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (io_start_i) begin
               if (io_len_i != '0) begin
                  state_d = ST_RUN;
                  rem_d   = io_len_i;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_RUN: begin
            if (issue) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_is_one) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      s1_v_d = issue;
      l1_d   = issue && rem_is_one;
      s2_v_d = s1_v_q;
      l2_d   = l1_q;
   end

   // Output FIFO pointer and occupancy next state
   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (push) tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
      if (pop)  head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // Constant registers load only in IDLE; a write anywhere else is flagged
   always_comb begin
      b_d       = b_q;
      c_d       = c_q;
      cfg_err_d = 1'b0;
      if (io_cfg_we_i) begin
         if (state_q == ST_IDLE) begin
            b_d = io_cfg_b_i;
            c_d = io_cfg_c_i;
         end else begin
            cfg_err_d = 1'b1;
         end
      end
   end

   // Control state registers with synchronous reset
   always_ff @(posedge io_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (io_rst) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         s1_v_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         l1_q       <= 1'b0;
         l2_q       <= 1'b0;
         fifo_cnt_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         b_q        <= '0;
         c_q        <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         s1_v_q     <= s1_v_d;
         s2_v_q     <= s2_v_d;
         l1_q       <= l1_d;
         l2_q       <= l2_d;
         fifo_cnt_q <= fifo_cnt_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         b_q        <= b_d;
         c_q        <= c_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // FIFO storage captures {last, result} when the stage-2 tag is valid
   always_ff @(posedge io_clk) begin
      // NOTE: storage is not reset; stale entries are unreachable once the pointers and count clear.
      if (push) mem_q[tail_q] <= {l2_q, io_gelu_data_i};
   end

   // The credit rule must keep the FIFO from being pushed while full
   assert property (@(posedge io_clk) disable iff (io_rst) !(push && fifo_cnt_q == CNT_FULL));

   assign io_busy_o           = state_q != ST_IDLE;
   assign io_done_o           = drain_done;
   assign io_cfg_err_o        = cfg_err_q;
   assign io_in_ready_o       = (state_q == ST_RUN) && credit;
   assign io_out_valid_o      = !fifo_empty;
   assign io_out_data_o       = fifo_empty ? '0 : mem_q[head_q][25:0];
   assign io_out_last_o       = fifo_empty ? 1'b0 : mem_q[head_q][26];
   assign io_gelu_data_o      = io_in_data_i;
   assign io_gelu_b_o         = b_q;
   assign io_gelu_c_o         = c_q;
   assign io_gelu_calc_en_o   = issue;
   assign io_gelu_calc_en_q_o = s1_v_q;

endmodule

// File: tb/tb_ita_gelu_ctrl.sv
// Testbench for ita_gelu_ctrl: a behavioural two-stage datapath model feeds
// results back. Expected beats are queued at each input handshake and checked
// by an independent output monitor.
module tb_ita_gelu_ctrl;

   localparam int LEN_W  = 16;
   localparam int BUDGET = 20000;

   logic clk, rst;
   logic start, busy, done, cfg_we, cfg_err;
   logic [LEN_W-1:0] len_i;
   logic [15:0] cfg_b, cfg_c, gelu_b, gelu_c;
   logic in_valid, in_ready, out_valid, out_ready, out_last;
   logic [7:0] in_data, gelu_data_o;
   logic [25:0] out_data, gelu_data_i, dp1, dp2;
   logic calc_en, calc_en_q;

   ita_gelu_ctrl #(.FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
      .io_clk(clk), .io_rst(rst),
      .io_start_i(start), .io_len_i(len_i), .io_busy_o(busy), .io_done_o(done),
      .io_cfg_we_i(cfg_we), .io_cfg_b_i(cfg_b), .io_cfg_c_i(cfg_c), .io_cfg_err_o(cfg_err),
      .io_in_valid_i(in_valid), .io_in_ready_o(in_ready), .io_in_data_i(in_data),
      .io_out_valid_o(out_valid), .io_out_ready_i(out_ready),
      .io_out_data_o(out_data), .io_out_last_o(out_last),
      .io_gelu_data_o(gelu_data_o), .io_gelu_b_o(gelu_b), .io_gelu_c_o(gelu_c),
      .io_gelu_calc_en_o(calc_en), .io_gelu_calc_en_q_o(calc_en_q),
      .io_gelu_data_i(gelu_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [25:0] dp_model(input logic [7:0] x, input logic [15:0] b,
                                            input logic [15:0] c);
      return {x, b, 2'b01} ^ {10'd0, c};
   endfunction

   // Free-running two-stage datapath stand-in
   always @(posedge clk) begin
      dp1 <= dp_model(gelu_data_o, gelu_b, gelu_c);
      dp2 <= dp1;
   end
   assign gelu_data_i = dp2;

   int n_checks = 0;
   int n_err    = 0;
   logic [26:0] sb [$];
   logic [15:0] cur_b, cur_c;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor state
   bit   mon_en = 0;
   int   m_beats, m_lasts, m_gap, m_first_out, m_last_out;
   int   m_done_cnt = 0, m_done_cyc = -1, m_err_cnt = 0, m_err_cyc = -1;
   logic prev_hs = 1'b0, prev_hold = 1'b0;
   logic [25:0] prev_data;

   initial begin
      logic [26:0] exp;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("calc_en", 32'(calc_en), 32'(in_valid && in_ready));
            check("calc_en_q", 32'(calc_en_q), 32'(prev_hs));
            if (prev_hold) begin
               check("hold_valid", 32'(out_valid), 32'(1));
               check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_beat", 32'(sb.size()), 32'(1));
               end else begin
                  exp = sb.pop_front();
                  check("out_data", 32'(out_data), 32'(exp[25:0]));
                  check("out_last", 32'(out_last), 32'(exp[26]));
               end
               if (m_beats > 0 && cyc != m_last_out + 1) m_gap++;
               if (m_beats == 0) m_first_out = cyc;
               m_last_out = cyc;
               m_beats++;
               if (out_last) m_lasts++;
            end
            if (done) begin
               m_done_cnt++;
               m_done_cyc = cyc;
            end
            if (cfg_err) begin
               m_err_cnt++;
               m_err_cyc = cyc;
            end
         end
         prev_hs   = rst ? 1'b0 : (in_valid && in_ready);
         prev_hold = !rst && out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   // Per-frame stimulus results
   int   f_start_cyc, f_first_hs, f_last_hs, f_sent, f_hold_acc, f_we_cyc;
   logic f_hold_ready, f_rel0, f_rel1, f_ready_any;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // vmode: 0 valid held, 1 random valid. rmode: 0 ready held, 1 random, 2 blocked for `hold` cycles.
   task automatic run_frame(input string tag, input int len, input int vmode, input int rmode,
                            input int hold, input bit bad_cfg, input bit new_cfg,
                            input logic [15:0] nb, input logic [15:0] nc);
      int sent = 0;
      int n = 0;
      int d0 = m_done_cnt;
      m_beats = 0; m_lasts = 0; m_gap = 0; m_first_out = -1; m_last_out = -1;
      f_first_hs = -1; f_last_hs = -1; f_hold_acc = 0; f_we_cyc = -1;
      f_hold_ready = 1'bx; f_rel0 = 1'bx; f_rel1 = 1'bx; f_ready_any = 1'b0;
      if (new_cfg) begin
         cfg_we = 1'b1; cfg_b = nb; cfg_c = nc; cur_b = nb; cur_c = nc;
      end
      start = 1'b1;
      len_i = LEN_W'(len);
      f_start_cyc = cyc;
      tick();
      start = 1'b0;
      cfg_we = 1'b0;
      while (m_done_cnt == d0 && n < BUDGET) begin
         in_valid = (sent < len) && (vmode == 0 || $urandom_range(1, 0) == 1);
         in_data  = (vmode == 0) ? 8'(sent * 37 + len + 5) : 8'($urandom);
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(1, 0) == 1);
            default: out_ready = (n >= hold);
         endcase
         if (bad_cfg && n == 0) begin
            cfg_we = 1'b1; cfg_b = 16'h1234; cfg_c = 16'h5678; f_we_cyc = cyc;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         if (in_ready) f_ready_any = 1'b1;
         if (in_valid && in_ready) begin
            sb.push_back({(sent == len - 1), dp_model(in_data, cur_b, cur_c)});
            if (f_first_hs < 0) f_first_hs = cyc;
            f_last_hs = cyc;
            if (rmode == 2 && n < hold) f_hold_acc++;
            sent++;
         end
         if (rmode == 2 && n == hold - 1) f_hold_ready = in_ready;
         if (rmode == 2 && n == hold)     f_rel0 = in_ready;
         if (rmode == 2 && n == hold + 1) f_rel1 = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      f_sent   = sent;
      repeat (3) tick();
      out_ready = 1'b0;
      check({tag, "_done_once"}, 32'(m_done_cnt - d0), 32'(1));
      check({tag, "_idle"}, 32'(busy), 32'(0));
      check({tag, "_sent"}, 32'(f_sent), 32'(len));
      check({tag, "_beats"}, 32'(m_beats), 32'(len));
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
      if (len > 0) begin
         check({tag, "_lasts"}, 32'(m_lasts), 32'(1));
         check({tag, "_done_after_last_pop"}, 32'(m_done_cyc), 32'(m_last_out + 1));
      end
   endtask

   initial begin
      int d0;
      rst = 1'b1; start = 1'b0; len_i = '0; cfg_we = 1'b0; cfg_b = '0; cfg_c = '0;
      in_valid = 1'b0; in_data = 8'h5A; out_ready = 1'b0; cur_b = '0; cur_c = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1;

      // Reset state
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      check("rst_cfg_err", 32'(cfg_err), 32'(0));
      check("rst_b", 32'(gelu_b), 32'(0));
      check("rst_c", 32'(gelu_c), 32'(0));
      check("rst_gelu_data", 32'(gelu_data_o), 32'(8'h5A));
      in_data = 8'hC3;
      #1;
      check("gelu_data_passthru", 32'(gelu_data_o), 32'(8'hC3));

      // Config write in IDLE
      cfg_we = 1'b1; cfg_b = 16'h0100; cfg_c = 16'hFF00;
      tick();
      cfg_we = 1'b0; cur_b = 16'h0100; cur_c = 16'hFF00;
      check("cfg_b", 32'(gelu_b), 32'(16'h0100));
      check("cfg_c", 32'(gelu_c), 32'(16'hFF00));
      check("cfg_no_err", 32'(cfg_err), 32'(0));

      // Config write during RUN is dropped and flagged
      d0 = m_err_cnt;
      run_frame("badcfg", 3, 0, 0, 0, 1'b1, 1'b0, 16'h0, 16'h0);
      check("badcfg_b_kept", 32'(gelu_b), 32'(16'h0100));
      check("badcfg_c_kept", 32'(gelu_c), 32'(16'hFF00));
      check("badcfg_err_once", 32'(m_err_cnt - d0), 32'(1));
      check("badcfg_err_cycle", 32'(m_err_cyc), 32'(f_we_cyc + 1));

      // Streaming at full rate
      run_frame("stream", 8, 0, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      check("stream_first_hs", 32'(f_first_hs), 32'(f_start_cyc + 1));
      check("stream_hs_consecutive", 32'(f_last_hs - f_first_hs), 32'(7));
      check("stream_out_latency", 32'(m_first_out), 32'(f_first_hs + 3));
      check("stream_out_gaps", 32'(m_gap), 32'(0));

      // Backpressure
      run_frame("bp", 10, 0, 2, 20, 1'b0, 1'b0, 16'h0, 16'h0);
      check("bp_accepted_while_blocked", 32'(f_hold_acc), 32'(4));
      check("bp_ready_low_blocked", 32'(f_hold_ready), 32'(0));
      check("bp_ready_low_pop_cycle", 32'(f_rel0), 32'(0));
      check("bp_ready_back_after_pop", 32'(f_rel1), 32'(1));

      // Zero length
      run_frame("zero", 0, 0, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
      check("zero_done_cycle", 32'(m_done_cyc), 32'(f_start_cyc + 1));
      check("zero_no_ready", 32'(f_ready_any), 32'(0));

      // Random throttling on both sides
      run_frame("rand", 1000, 1, 1, 0, 1'b0, 1'b0, 16'h0, 16'h0);

      // Reset mid-frame with three results stored
      start = 1'b1; len_i = LEN_W'(10); out_ready = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i + 100);
         @(negedge clk);
         if (in_valid && in_ready) sb.push_back({1'b0, dp_model(in_data, cur_b, cur_c)});
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("mid_valid_before_rst", 32'(out_valid), 32'(1));
      d0 = m_done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("mid_out_valid_cleared", 32'(out_valid), 32'(0));
      check("mid_busy_cleared", 32'(busy), 32'(0));
      check("mid_in_ready_cleared", 32'(in_ready), 32'(0));
      check("mid_calc_en_q_cleared", 32'(calc_en_q), 32'(0));
      repeat (5) tick();
      check("mid_no_done", 32'(m_done_cnt - d0), 32'(0));
      check("mid_still_empty", 32'(out_valid), 32'(0));

      // New frame after reset, loading new constants together with start
      run_frame("post", 2, 0, 0, 0, 1'b0, 1'b1, 16'hBEEF, 16'h0F0F);
      check("post_b", 32'(gelu_b), 32'(16'hBEEF));
      check("post_c", 32'(gelu_c), 32'(16'h0F0F));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", n_err, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
